issue_wf_arbiter: RTL
=====================

# issue_wf_arbiter

Round-robin scheduler for the issue stage. Chooses one of 40 wavefront slots per issue, holds the choice until the downstream functional unit accepts it, and drives the 6-bit select of the 40:1 wavefront-field mux. A granted wavefront is locked out until the functional unit releases it.

## Interface
Parameters:
- NUM_WF, 40, number of wavefront slots; fixed at 40 for this design.
- WF_ID_WIDTH, 6, width of a wavefront id.

Ports:
- clk  input  1  clock; every register updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NUM_WF  bit i set means wavefront i is ready to issue.
- accept  input  1  downstream FU takes the current grant this cycle.
- release_valid  input  1  FU finished a wavefront; release_wfid is valid.
- release_wfid  input  WF_ID_WIDTH  id of the finished wavefront.
- grant_valid  output  1  a grant is being presented.
- grant_wfid  output  WF_ID_WIDTH  granted id; drives the mux select.
- grant_onehot  output  NUM_WF  one-hot copy of grant_wfid; all zero when grant_valid=0.

## Operation
- State: pending[39:0] (locked ids), ptr[5:0] (search start, 0..39), grant register, FSM {IDLE, GRANT}.
- eligible = req & ~pending.
- Search order: ptr, ptr+1, …, 39, 0, …, ptr−1. The first eligible id wins.
- IDLE: if any eligible bit is set, register the winner and go to GRANT. Otherwise stay in IDLE.
- GRANT with accept=0:
  - Hold grant_wfid and grant_onehot stable.
  - No re-arbitration, even if req for the granted id drops. Grants are never retracted.
- GRANT with accept=1:
  - Set pending[grant_wfid].
  - ptr <= (grant_wfid==39) ? 0 : grant_wfid+1.
  - Re-arbitrate in the same edge, using the updated ptr and with the accepted id excluded. If a winner exists, stay in GRANT with the new id. Otherwise go to IDLE.
- accept while grant_valid=0 is ignored.
- Release:
  - release_valid=1 clears pending[release_wfid] at the edge.
  - A released id is eligible from the next cycle's arbitration, not the same cycle.
  - release_wfid ≥ 40 is ignored.
  - Release of a non-pending id is a no-op.
- Release and accept of different ids in the same cycle: both take effect.
- Release and accept of the same id cannot be legal. Accept wins: the bit ends up set.
- grant_wfid keeps its last value in IDLE. grant_onehot is zero in IDLE.
- Id arithmetic is 6-bit modulo 40. Never compute 40 as an id.

## Timing
- Reset values: grant_valid=0, grant_wfid=0, grant_onehot=0, pending=0, ptr=0, FSM=IDLE. Reset acts immediately, without waiting for a clock edge, including in the middle of a grant.
- Latency: req sampled at edge N, grant_valid visible after edge N (from cycle N+1). That is 1 cycle from req to grant.
- Throughput: one grant per cycle when accept is held high and eligible ids exist.
- All outputs are registered. There is no combinational path from req, accept or release to any output.
- accept is sampled only on the edge; the FU may assert it in the same cycle it sees grant_valid.

## Test plan
- Reset and single request:
  - Stimulus: assert rst mid-cycle, then release it; req=1<<5, accept=1.
  - Required: outputs zero during reset. grant_valid=1, grant_wfid=5 one cycle after the req edge. pending[5]=1 after accept. grant_valid=0 the next cycle.
- Round-robin order and wrap:
  - Stimulus: req=all 1s, accept=1 every cycle, release each id the cycle after its grant.
  - Required: grants 0,1,2,…,39,0,1,… on consecutive cycles, with no gaps.
- Pointer fairness:
  - Stimulus: ptr=38 (after granting 37); req bits {2, 38, 39}.
  - Required: grant order 38, 39, 2.
- Backpressure hold:
  - Stimulus: grant 12 with accept=0 for 5 cycles while req[12] drops and req[3] rises.
  - Required: grant_wfid stays 12 with grant_valid=1 throughout. After accept, next grant is 3.
- Pending lockout and release:
  - Stimulus: accept 7 while req[7] stays high; release_valid with id 7 three cycles later.
  - Required: 7 is not granted again before the release edge. It is granted the cycle after the release takes effect.
  - Stimulus: release_wfid=45.
  - Required: no state change.
- Async reset during GRANT:
  - Stimulus: assert rst between edges while grant_valid=1 and pending is nonzero.
  - Required: grant_valid, grant_onehot and pending go to 0 immediately. After reset, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/issue_wf_arbiter.sv
// rtl/issue_wf_arbiter.sv - round-robin wavefront issue arbiter with accept hold and pending lockout
//
// Picks one of NUM_WF wavefront slots per issue in round-robin order, holds the
// grant until the functional unit accepts it, then locks the accepted id out
// until the functional unit releases it.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   req           per-wavefront ready bits
//   accept        FU takes the presented grant at this edge
//   release_valid FU finished a wavefront (release_wfid valid)
//   release_wfid  id of the finished wavefront; ids >= NUM_WF are ignored
//   grant_valid   a grant is being presented
//   grant_wfid    granted id (mux select); holds its last value while idle
//   grant_onehot  one-hot copy of grant_wfid, zero while idle
module issue_wf_arbiter #(
    parameter int NUM_WF      = 40,
    parameter int WF_ID_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_WF-1:0]      req,
    input  logic                   accept,
    input  logic                   release_valid,
    input  logic [WF_ID_WIDTH-1:0] release_wfid,
    output logic                   grant_valid,
    output logic [WF_ID_WIDTH-1:0] grant_wfid,
    output logic [NUM_WF-1:0]      grant_onehot
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [WF_ID_WIDTH-1:0] LAST_ID = WF_ID_WIDTH'(NUM_WF - 1);

    state_t                   state, next_state;
    logic [NUM_WF-1:0]        pending, next_pending;
    logic [WF_ID_WIDTH-1:0]   ptr, next_ptr;
    logic [WF_ID_WIDTH-1:0]   next_grant_wfid;
    logic [NUM_WF-1:0]        next_grant_onehot;

    logic                     acc_fire;
    logic [NUM_WF-1:0]        acc_mask;
    logic [NUM_WF-1:0]        rel_mask;
    logic [WF_ID_WIDTH-1:0]   ptr_after;
    logic [NUM_WF-1:0]        search_elig;
    logic [WF_ID_WIDTH-1:0]   search_start;
    logic                     win_found;
    logic [WF_ID_WIDTH-1:0]   win_id;

    // accept only counts while a grant is actually presented
    assign acc_fire  = (state == GRANT) && accept;
    assign acc_mask  = acc_fire ? grant_onehot : '0;
    assign ptr_after = (grant_wfid == LAST_ID) ? '0 : grant_wfid + 1'b1;

    // Eligibility uses the pre-release pending vector, so a released id only
    // becomes eligible one cycle after the release edge. The accepted id is
    // masked so the same-edge re-arbitration cannot pick it again.
    assign search_elig  = req & ~(pending | acc_mask);
    assign search_start = acc_fire ? ptr_after : ptr;

    always_comb begin
        rel_mask = '0;
        if (release_valid && (release_wfid < WF_ID_WIDTH'(NUM_WF))) begin
            rel_mask[release_wfid] = 1'b1;
        end
    end

    // Round-robin search: first eligible id starting at search_start, wrapping
    // modulo NUM_WF. The sum is one bit wider so it can be wrapped before use
    // and never forms an out-of-range id.
    always_comb begin
        logic [WF_ID_WIDTH:0]   sum;
        logic [WF_ID_WIDTH-1:0] idx;
        win_found = 1'b0;
        win_id    = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_WF; k++) begin
            sum = {1'b0, search_start} + (WF_ID_WIDTH + 1)'(k);
            if (sum >= (WF_ID_WIDTH + 1)'(NUM_WF)) begin
                sum = sum - (WF_ID_WIDTH + 1)'(NUM_WF);
            end
            idx = sum[WF_ID_WIDTH-1:0];
            if (!win_found && search_elig[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        next_state        = state;
        next_ptr          = ptr;
        next_grant_wfid   = grant_wfid;
        next_grant_onehot = grant_onehot;
        // accept is ORed in after the release clear: accept wins on the same id
        next_pending      = (pending & ~rel_mask) | acc_mask;

        case (state)
            IDLE: begin
                if (win_found) begin
                    next_state              = GRANT;
                    next_grant_wfid         = win_id;
                    next_grant_onehot       = '0;
                    next_grant_onehot[win_id] = 1'b1;
                end
            end
            GRANT: begin
                // without accept the grant is held; it is never retracted
                if (accept) begin
                    next_ptr = ptr_after;
                    if (win_found) begin
                        next_grant_wfid         = win_id;
                        next_grant_onehot       = '0;
                        next_grant_onehot[win_id] = 1'b1;
                    end else begin
                        next_state        = IDLE;
                        next_grant_onehot = '0;
                    end
                end
            end
            default: begin
                next_state        = IDLE;
                next_grant_onehot = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            ptr          <= '0;
            grant_wfid   <= '0;
            grant_onehot <= '0;
        end else begin
            state        <= next_state;
            pending      <= next_pending;
            ptr          <= next_ptr;
            grant_wfid   <= next_grant_wfid;
            grant_onehot <= next_grant_onehot;
        end
    end

    assign grant_valid = (state == GRANT);

endmodule
